// File: rtl/nn_pkg.sv
// Shared types and helpers for the network output stage.
// Holds the packer FSM state enum and the unsigned saturation helper.
package nn_pkg;

  typedef enum logic [0:0] {
    s_COLLECT,
    s_HOLD
  } t_packer_states;

  // Clamp a signed value into [0, 2^width-1]; result is zero-extended to 64 bits.
  function automatic logic [63:0] sat_unsigned(input logic signed [63:0] value,
                                               input int unsigned        width);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< width) - 64'sd1;
    if (value < 64'sd0) begin
      return '0;
    end else if (value > max_v) begin
      return max_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/score_requant.sv
// Combinational requantizer: arithmetic shift of a signed accumulator, then unsigned clamp.
// Round-half-up before the shift when SCORE_PACKER_ROUND_EN is defined.
module score_requant
  import nn_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SHIFT      = 8
) (
  input  logic [ACC_WIDTH-1:0]  i_acc,
  output logic [DATA_WIDTH-1:0] o_score
);

`ifdef SCORE_PACKER_ROUND_EN
  // 2^(SHIFT-1), or zero when SHIFT is 0.
  localparam logic [63:0] RoundAdd64 = (64'd1 << SHIFT) >> 1;
`endif

  logic signed [ACC_WIDTH:0] t_ext;
  logic signed [ACC_WIDTH:0] t_rnd;
  logic signed [ACC_WIDTH:0] t_sh;
  logic        [63:0]        sat;
  logic                      unused_sat_msb;

  always_comb begin
    // One extra bit so the rounding add cannot overflow.
    t_ext = $signed({i_acc[ACC_WIDTH-1], i_acc});
`ifdef SCORE_PACKER_ROUND_EN
    t_rnd = t_ext + $signed(RoundAdd64[ACC_WIDTH:0]);
`else
    t_rnd = t_ext;
`endif
    t_sh    = t_rnd >>> SHIFT;
    sat     = sat_unsigned({{(63 - ACC_WIDTH){t_sh[ACC_WIDTH]}}, t_sh}, DATA_WIDTH);
    o_score = sat[DATA_WIDTH-1:0];
  end

  assign unused_sat_msb = ^sat[63:DATA_WIDTH];

endmodule

// File: rtl/score_packer.sv
// Packs requantized per-class scores into one wide vector with valid/ready output.
// Build option: SCORE_PACKER_ROUND_EN selects round-half-up in the requantizer.
module score_packer
  import nn_pkg::*;
#(
  parameter int unsigned N_PARALLEL = 30,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [ACC_WIDTH-1:0]             i_data,
  input  logic                             i_valid,
  input  logic                             i_last,
  output logic                             o_ready,
  input  logic                             i_ready,
  output logic [N_PARALLEL*DATA_WIDTH-1:0] o_data,
  output logic                             o_valid,
  output logic                             o_error
);

  localparam int unsigned     CntW   = $clog2(N_PARALLEL);
  localparam logic [CntW-1:0] CntMax = CntW'(N_PARALLEL - 1);

  t_packer_states                         r_state;
  logic [CntW-1:0]                        r_cntr;
  logic [N_PARALLEL-1:0][DATA_WIDTH-1:0]  r_stage;
  logic [N_PARALLEL-1:0][DATA_WIDTH-1:0]  packed_next;
  logic [DATA_WIDTH-1:0]                  score;
  logic                                   accept;
  logic                                   is_final;
  logic                                   exact_end;

  score_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .SHIFT     (SHIFT)
  ) u_requant (
    .i_acc  (i_data),
    .o_score(score)
  );

  // Ready combinationally follows the downstream ready while a vector is held.
  assign o_ready   = (r_state == s_COLLECT) || i_ready;
  assign accept    = i_valid && o_ready;
  assign exact_end = i_last && (r_cntr == CntMax);
  assign is_final  = i_last || (r_cntr == CntMax);

  // Staged slots below the current one, current beat in its slot, zeros above.
  always_comb begin
    packed_next = '0;
    for (int k = 0; k < N_PARALLEL; k++) begin
      if (CntW'(k) < r_cntr) begin
        packed_next[k] = r_stage[k];
      end else if (CntW'(k) == r_cntr) begin
        packed_next[k] = score;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= s_COLLECT;
      r_cntr  <= '0;
      r_stage <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_error <= 1'b0;
    end else begin
      o_error <= 1'b0;
      if (accept && is_final) begin
        // Covers both a fresh load and a reload in the same cycle as a drain.
        o_data  <= packed_next;
        o_valid <= 1'b1;
        o_error <= !exact_end;
        r_stage <= '0;
        r_cntr  <= '0;
        r_state <= s_HOLD;
      end else begin
        if (accept) begin
          r_stage[r_cntr] <= score;
          r_cntr          <= r_cntr + CntW'(1);
        end
        if (r_state == s_HOLD && i_ready) begin
          r_state <= s_COLLECT;
          o_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_packer.sv
// Directed table-driven bench for score_packer (N_PARALLEL=4, SHIFT=8).
module tb_score_packer;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 32;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [AW-1:0]     i_data;
  logic              i_valid;
  logic              i_last;
  logic              o_ready;
  logic              i_ready;
  logic [NP*DW-1:0]  o_data;
  logic              o_valid;
  logic              o_error;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  score_packer #(
    .N_PARALLEL(NP),
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .SHIFT     (8)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_last (i_last),
    .o_ready(o_ready),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_error(o_error)
  );

  typedef struct {
    logic [NP-1:0][AW-1:0] d;
    logic [NP-1:0]         last;
    int                    n;
    logic [NP-1:0][DW-1:0] exp;
    logic                  err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input logic [AW-1:0] d, input logic l);
    int waits = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    #1;
    while (!o_ready && waits < 50) begin
      @(negedge i_clk);
      waits++;
    end
    if (!o_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_timeout: o_ready got 0, expected 1");
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    logic [NP-1:0][DW-1:0] ex_a;
    logic [NP-1:0][DW-1:0] ex_b;
    logic [DW-1:0]         rnd_exp;

`ifdef SCORE_PACKER_ROUND_EN
    rnd_exp = 16'd2;
`else
    rnd_exp = 16'd1;
`endif

    vecs[0].d = {32'h400, 32'h300, 32'h200, 32'h100};
    vecs[0].last = 4'b1000; vecs[0].n = 4;
    vecs[0].exp = {16'd4, 16'd3, 16'd2, 16'd1}; vecs[0].err = 1'b0;

    vecs[1].d = {32'h0, 32'h00FFFF00, 32'h7FFFFFFF, 32'hFFFFFB00};
    vecs[1].last = 4'b1000; vecs[1].n = 4;
    vecs[1].exp = {16'h0, 16'hFFFF, 16'hFFFF, 16'h0}; vecs[1].err = 1'b0;

    vecs[2].d = {32'h0, 32'h0, 32'h600, 32'h500};
    vecs[2].last = 4'b0010; vecs[2].n = 2;
    vecs[2].exp = {16'd0, 16'd0, 16'd6, 16'd5}; vecs[2].err = 1'b1;

    vecs[3].d = {32'hD00, 32'hC00, 32'hB00, 32'hA00};
    vecs[3].last = 4'b0000; vecs[3].n = 4;
    vecs[3].exp = {16'hD, 16'hC, 16'hB, 16'hA}; vecs[3].err = 1'b1;

    vecs[4].d = {32'h1800, 32'h1700, 32'h1600, 32'h1500};
    vecs[4].last = 4'b1000; vecs[4].n = 4;
    vecs[4].exp = {16'h18, 16'h17, 16'h16, 16'h15}; vecs[4].err = 1'b0;

    vecs[5].d = {32'h0, 32'h0, 32'h0, 32'h180};
    vecs[5].last = 4'b0001; vecs[5].n = 1;
    vecs[5].exp = {16'd0, 16'd0, 16'd0, rnd_exp}; vecs[5].err = 1'b1;

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("reset_valid", o_valid, 0);
    chk("reset_data", o_data, 0);
    chk("reset_error", o_error, 0);
    chk("reset_ready", o_ready, 1);
    i_reset = 1'b0;
    @(negedge i_clk);

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].n; b++) beat(vecs[v].d[b], vecs[v].last[b]);
      chk($sformatf("vec%0d_valid", v), o_valid, 1);
      chk($sformatf("vec%0d_data", v), o_data, vecs[v].exp);
      chk($sformatf("vec%0d_error", v), o_error, vecs[v].err);
      i_valid = 1'b0;
      i_last  = 1'b0;
      @(negedge i_clk);
      chk($sformatf("vec%0d_drain", v), o_valid, 0);
      chk($sformatf("vec%0d_err_pulse", v), o_error, 0);
    end

    // Backpressure: held output stalls the next vector's beats.
    ex_a = {16'd4, 16'd3, 16'd2, 16'd1};
    ex_b = {16'd8, 16'd7, 16'd6, 16'd5};
    i_ready = 1'b0;
    beat(32'h100, 1'b0);
    beat(32'h200, 1'b0);
    beat(32'h300, 1'b0);
    beat(32'h400, 1'b1);
    i_data = 32'h500;
    i_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("stall%0d_ready", c), o_ready, 0);
      chk($sformatf("stall%0d_valid", c), o_valid, 1);
      chk($sformatf("stall%0d_data", c), o_data, ex_a);
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    beat(32'h500, 1'b0);
    chk("bp_drained", o_valid, 0);
    beat(32'h600, 1'b0);
    beat(32'h700, 1'b0);
    beat(32'h800, 1'b1);
    chk("bp_b_valid", o_valid, 1);
    chk("bp_b_data", o_data, ex_b);
    chk("bp_b_error", o_error, 0);
    // Final beat accepted during the drain cycle reloads with no bubble.
    beat(32'h900, 1'b1);
    chk("reload_valid", o_valid, 1);
    chk("reload_data", o_data, {16'd0, 16'd0, 16'd0, 16'd9});
    chk("reload_error", o_error, 1);
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(negedge i_clk);
    chk("reload_drain", o_valid, 0);

    // Reset drops a held output immediately.
    i_ready = 1'b0;
    beat(32'h300, 1'b1);
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("pre_reset_valid", o_valid, 1);
    #1 i_reset = 1'b1;
    #1;
    chk("async_reset_valid", o_valid, 0);
    chk("async_reset_data", o_data, 0);
    chk("async_reset_ready", o_ready, 1);
    @(negedge i_clk);
    i_reset = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);

    // Reset mid-vector discards the partial vector.
    beat(32'h100, 1'b0);
    beat(32'h200, 1'b0);
    i_valid = 1'b0;
    #1 i_reset = 1'b1;
    #1;
    chk("midvec_reset_error", o_error, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    beat(32'h1100, 1'b0);
    beat(32'h1200, 1'b0);
    beat(32'h1300, 1'b0);
    beat(32'h1400, 1'b1);
    chk("clean_valid", o_valid, 1);
    chk("clean_data", o_data, {16'h14, 16'h13, 16'h12, 16'h11});
    chk("clean_error", o_error, 0);
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(negedge i_clk);
    chk("clean_drain", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/score_packer.md
# score_packer

Gathers the output-layer neuron results of the network, which arrive one signed accumulator per beat. Each result is requantized and saturated to an unsigned DATA_WIDTH score. N_PARALLEL scores are packed into one wide vector and handed to the arg-max stage over a valid/ready handshake. Slot k of the vector (bits k*DATA_WIDTH +: DATA_WIDTH) holds class k.

## Interface
Parameters:
- N_PARALLEL, 30, number of classes (beats) per vector; must be ≥ 2
- DATA_WIDTH, 16, width of each packed score
- ACC_WIDTH, 32, width of incoming signed accumulator
- SHIFT, 8, arithmetic right shift applied before saturation; range 0..ACC_WIDTH-1

Ports:
- i_clk  in  1  single clock
- i_reset  in  1  reset, asynchronous and active-high
- i_data  in  ACC_WIDTH  signed accumulator of the current class
- i_valid  in  1  slave beat valid
- i_last  in  1  marks the final beat of a vector
- o_ready  out  1  slave ready
- i_ready  in  1  master ready from the arg-max stage
- o_data  out  N_PARALLEL*DATA_WIDTH  packed scores
- o_valid  out  1  master valid
- o_error  out  1  one-cycle pulse: vector length mismatch

## Operation
- A beat is accepted when i_valid && o_ready.
- Beat counter r_cntr (width $clog2(N_PARALLEL)) selects the staging slot. The first beat goes to slot 0.
- Requant of each beat:
  - t = sign-extend(i_data) to ACC_WIDTH+1, then t >>>= SHIFT.
  - Clamp: t < 0 gives 0; t > 2^DATA_WIDTH-1 gives 2^DATA_WIDTH-1; otherwise t[DATA_WIDTH-1:0].
- A beat is final when i_last=1 or r_cntr==N_PARALLEL-1. On the final beat:
  - Staging slots plus the current beat are copied to o_data in one cycle.
  - Slots above the final slot are forced to 0.
  - Staging is cleared and r_cntr returns to 0.
- Error rule: o_error pulses together with the output load when the final beat is not exactly (i_last=1 and r_cntr==N_PARALLEL-1).
  - An early i_last emits a short, zero-filled vector.
  - A missing i_last on slot N_PARALLEL-1 still emits the vector.
- FSM states:
  - s_COLLECT: output register empty. A final beat moves the FSM to s_HOLD.
  - s_HOLD: o_valid=1, o_data stable. If i_ready=1 and no final beat is accepted the same cycle, go to s_COLLECT. If i_ready=1 and a final beat is accepted the same cycle, reload o_data and stay in s_HOLD.
- o_ready = (state==s_COLLECT) || i_ready. This combinational path from i_ready is intentional.
- Beats for slots below the final slot are also gated by o_ready while in s_HOLD.

## Timing
- Reset (async assert, sync release): state=s_COLLECT, r_cntr=0, staging=0, o_data=0, o_valid=0, o_error=0. o_ready is therefore 1 out of reset.
- Latency: o_valid rises on the clock edge after the final beat is accepted (1 cycle).
- Throughput: one beat per cycle. A new vector may start the cycle after the previous final beat.
- o_data and o_valid hold while o_valid && !i_ready. o_valid never drops without a handshake.
- i_valid=0 mid-vector: r_cntr holds and there is no timeout.
- Reset mid-vector: the partial vector is discarded and the held output is dropped. No o_error.

## Configuration
- SCORE_PACKER_ROUND_EN defined: add 2^(SHIFT-1) to t before the shift (round half up). With SHIFT=0 nothing is added.
- Not defined: plain truncation toward −∞.
- The clamp is identical in both builds.

## Structure
- Shared package nn_pkg holds:
  - the t_packer_states enum (s_COLLECT, s_HOLD)
  - the function sat_unsigned(value, width)
- Sub-module score_requant: combinational; ACC_WIDTH in, DATA_WIDTH out. It contains the shift, the rounding under the macro, and the clamp.
- score_packer holds the FSM, counter, staging and output registers.

## Test plan
Use N_PARALLEL=4, DATA_WIDTH=16, ACC_WIDTH=32, SHIFT=8.
- Normal vector: beats 0x100, 0x200, 0x300, 0x400, with i_last on the 4th → next cycle o_valid=1, slots 0..3 = 1, 2, 3, 4, o_error=0.
- Saturation: beats 0xFFFFFB00 (−0x500), 0x7FFFFFFF, 0x00FFFF00, 0x0 → slots 0, 0xFFFF, 0xFFFF, 0.
- Early last: 2 beats 0x500, 0x600 with i_last on the 2nd → slots 5, 6, 0, 0; o_error pulses one cycle.
- Missing last: 4 beats with i_last=0 → vector emitted after beat 4, o_error=1. The next beat lands in slot 0.
- Backpressure:
  - Hold i_ready=0 for 6 cycles after the first o_valid.
  - The second vector's beats are stalled by o_ready until i_ready rises; o_data stays unchanged meanwhile.
  - With i_ready=1, a final beat accepted in the same cycle as the drain reloads o_data and keeps o_valid=1 with no bubble.
- Rounding and reset:
  - A beat of 0x180 gives 2 with SCORE_PACKER_ROUND_EN and 1 without.
  - Asserting i_reset after 2 beats → o_valid=0 immediately; the next 4 beats form a clean vector.
